// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int NUM_REGS_DEF = 32;
   localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

   typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: a reservation marks a register as awaiting a load
// result, and any enabled write to it clears the mark.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NUM_REGS = NUM_REGS_DEF,
   parameter  int NUM_WR   = 1,
   parameter  int ZERO_REG = 1,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_WR-1:0]        wr_en_i,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
   input  logic                     rsv_en_i,
   input  logic [ADDR_W-1:0]        rsv_addr_i,
   output logic [NUM_REGS-1:0]      busy_o
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // The reservation is applied last so it wins over a same-cycle write.
   always_comb begin
      busy_d = busy_q;
      for (int p = 0; p < NUM_WR; p++) begin
         if (wr_en_i[p]) busy_d[wr_addr_i[p*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (rsv_en_i && !(ZERO_REG != 0 && rsv_addr_i == '0)) busy_d[rsv_addr_i] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with load scoreboard and zero register.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int DATA_W   = DATA_W_DEF,
   parameter  int NUM_REGS = NUM_REGS_DEF,
   parameter  int NUM_RD   = 2,
   parameter  int NUM_WR   = 1,
   parameter  int ZERO_REG = 1,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic [NUM_WR-1:0]          wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]   wr_data,
   input  logic                       rsv_en,
   input  logic [ADDR_W-1:0]          rsv_addr,
   output logic [NUM_REGS*DATA_W-1:0] dbg_regs
);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy;

   // Later ports overwrite earlier ones, giving port 1 priority on a collision.
   always_comb begin
      regs_d = regs_q;
      for (int p = 0; p < NUM_WR; p++) begin
         if (wr_en[p] && !(ZERO_REG != 0 && wr_addr[p*ADDR_W +: ADDR_W] == '0))
            regs_d[wr_addr[p*ADDR_W +: ADDR_W]] = wr_data[p*DATA_W +: DATA_W];
      end
   end

   // NOTE: the storage array is reset explicitly because every address must
   // read zero while rst_n is low; this rules out mapping onto RAM macros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .rsv_en_i   (rsv_en),
      .rsv_addr_i (rsv_addr),
      .busy_o     (busy)
   );

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rv;

      assign ra = rd_addr[k*ADDR_W +: ADDR_W];

      always_comb begin
         rv = regs_q[ra];
`ifdef REGFILE_BYPASS_EN
         // Forwarding is gated by rst_n so reads stay zero during reset.
         for (int p = 0; p < NUM_WR; p++) begin
            if (rst_n && wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] == ra)
               rv = wr_data[p*DATA_W +: DATA_W];
         end
`endif
         if (ZERO_REG != 0 && ra == '0) rv = '0;
      end

      assign rd_data[k*DATA_W +: DATA_W] = rv;
      assign rd_busy[k]                  = busy[ra];
   end

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_dbg
      assign dbg_regs[r*DATA_W +: DATA_W] = regs_q[r];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (two write ports, two read ports, zero register).
module tb_regfile_mp;
   import regfile_pkg::*;

   localparam int DW  = 32;
   localparam int NR  = 32;
   localparam int NRD = 2;
   localparam int NWR = 2;
   localparam int AW  = $clog2(NR);

   logic              clk;
   logic              rst_n;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_busy;
   logic [NWR-1:0]    wr_en;
   logic [NWR*AW-1:0] wr_addr;
   logic [NWR*DW-1:0] wr_data;
   logic              rsv_en;
   logic [AW-1:0]     rsv_addr;
   logic [NR*DW-1:0]  dbg_regs;

   regfile_mp #(
      .DATA_W   (DW),
      .NUM_REGS (NR),
      .NUM_RD   (NRD),
      .NUM_WR   (NWR),
      .ZERO_REG (1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .dbg_regs (dbg_regs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: architectural register contents and busy flags.
   logic [DW-1:0] m_mem  [NR];
   bit            m_busy [NR];
   int            checks = 0;
   int            errors = 0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_rd(input addr_t a);
      logic [DW-1:0] v;
      if (!rst_n || a == 0) return '0;
      v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NWR; p++)
         if (wr_en[p] && addr_t'(wr_addr[p*AW +: AW]) == a) v = wr_data[p*DW +: DW];
`endif
      return v;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < NR; r++) begin
         m_mem[r]  = '0;
         m_busy[r] = 1'b0;
      end
   endtask

   task automatic set_in(input logic [1:0] we, input addr_t wa0, input logic [DW-1:0] wd0,
                         input addr_t wa1, input logic [DW-1:0] wd1,
                         input logic rsv, input addr_t ra_rsv, input addr_t ra0, input addr_t ra1);
      wr_en    = we;
      wr_addr  = {wa1, wa0};
      wr_data  = {wd1, wd0};
      rsv_en   = rsv;
      rsv_addr = ra_rsv;
      rd_addr  = {ra1, ra0};
   endtask

   task automatic idle(input addr_t ra0, input addr_t ra1);
      set_in(2'b00, 0, '0, 0, '0, 1'b0, 0, ra0, ra1);
   endtask

   // Compare all outputs against the model, then clock once and advance the model.
   task automatic cycle();
      #1;
      for (int k = 0; k < NRD; k++) begin
         addr_t a;
         a = rd_addr[k*AW +: AW];
         check($sformatf("rd_data%0d@r%0d", k, a), rd_data[k*DW +: DW], exp_rd(a));
         check($sformatf("rd_busy%0d@r%0d", k, a), DW'(rd_busy[k]), DW'(rst_n ? m_busy[a] : 1'b0));
      end
      for (int r = 0; r < NR; r++)
         check($sformatf("dbg_r%0d", r), dbg_regs[r*DW +: DW], m_mem[r]);
      @(posedge clk);
      if (rst_n) begin
         for (int p = 0; p < NWR; p++) begin
            if (wr_en[p]) begin
               addr_t wa;
               wa = wr_addr[p*AW +: AW];
               if (wa != 0) m_mem[wa] = wr_data[p*DW +: DW];
               m_busy[wa] = 1'b0;
            end
         end
         if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      model_reset();
      idle(0, 0);

      // Reset sweep: every address reads zero and not busy, writes are discarded.
      for (int a = 0; a < NR; a++) begin
         set_in(2'b11, addr_t'(a), $urandom, addr_t'(NR-1-a), $urandom, 1'b1, addr_t'(a),
                addr_t'(a), addr_t'(NR-1-a));
         #1;
         check("rst_rd0", rd_data[DW-1:0], '0);
         check("rst_busy", DW'(rd_busy), '0);
         cycle();
      end
      rst_n = 1'b1;

      // r5 write then read alongside r0.
      set_in(2'b01, 5, 32'hDEADBEEF, 0, '0, 1'b0, 0, 5, 0);
      cycle();
      idle(5, 0);
      #1;
      check("r5_read", rd_data[DW-1:0], 32'hDEADBEEF);
      check("r0_read", rd_data[2*DW-1:DW], '0);
      cycle();

      // Write to the zero register is dropped.
      set_in(2'b01, 0, 32'h1234, 0, '0, 1'b0, 0, 0, 0);
      cycle();
      idle(0, 5);
      #1;
      check("r0_zero", rd_data[DW-1:0], '0);
      check("dbg_r0", dbg_regs[DW-1:0], '0);
      cycle();

      // Both ports write r7: port 1 wins.
      set_in(2'b11, 7, 32'h1, 7, 32'h2, 1'b0, 0, 7, 7);
      cycle();
      idle(7, 5);
      #1;
      check("r7_collide", rd_data[DW-1:0], 32'h2);
      cycle();

      // Reservation, clear by write, reservation beating a same-cycle write.
      set_in(2'b00, 0, '0, 0, '0, 1'b1, 9, 9, 9);
      cycle();
      idle(9, 9);
      #1;
      check("r9_busy_set", DW'(rd_busy[0]), 32'h1);
      set_in(2'b01, 9, 32'hAA, 0, '0, 1'b0, 0, 9, 9);
      #1;
      check("r9_busy_before_edge", DW'(rd_busy[1]), 32'h1);
      cycle();
      idle(9, 9);
      #1;
      check("r9_busy_clr", DW'(rd_busy[0]), 32'h0);
      check("r9_data_aa", rd_data[DW-1:0], 32'hAA);
      set_in(2'b10, 0, '0, 9, 32'hBB, 1'b1, 9, 9, 9);
      cycle();
      idle(9, 9);
      #1;
      check("r9_rsv_wins", DW'(rd_busy[0]), 32'h1);
      check("r9_data_bb", rd_data[DW-1:0], 32'hBB);
      cycle();

      // Reservation of r0 is ignored; double reservation stays busy.
      set_in(2'b00, 0, '0, 0, '0, 1'b1, 0, 0, 9);
      cycle();
      set_in(2'b00, 0, '0, 0, '0, 1'b1, 9, 0, 9);
      cycle();
      idle(0, 9);
      #1;
      check("r0_never_busy", DW'(rd_busy[0]), 32'h0);
      check("r9_still_busy", DW'(rd_busy[1]), 32'h1);
      cycle();

      // Same-cycle write/read of r3.
      set_in(2'b01, 3, 32'h11, 0, '0, 1'b0, 0, 3, 3);
      cycle();
      set_in(2'b01, 3, 32'h55, 0, '0, 1'b0, 0, 3, 3);
      #1;
`ifdef REGFILE_BYPASS_EN
      check("r3_same_cycle", rd_data[DW-1:0], 32'h55);
`else
      check("r3_same_cycle", rd_data[DW-1:0], 32'h11);
`endif
      cycle();
      idle(3, 3);
      #1;
      check("r3_next_cycle", rd_data[DW-1:0], 32'h55);
      cycle();

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         set_in(2'($urandom_range(0, 3)), addr_t'($urandom), $urandom,
                addr_t'($urandom), $urandom, 1'($urandom_range(0, 3) == 0), addr_t'($urandom),
                addr_t'($urandom), addr_t'($urandom));
         cycle();
      end

      // Reset mid-operation discards same-cycle activity; first edge after release works.
      set_in(2'b11, 12, 32'hCAFE, 13, 32'hF00D, 1'b1, 12, 12, 13);
      rst_n = 1'b0;
      model_reset();
      cycle();
      rst_n = 1'b1;
      set_in(2'b01, 12, 32'h777, 0, '0, 1'b1, 13, 12, 13);
      cycle();
      idle(12, 13);
      #1;
      check("post_rst_wr", rd_data[DW-1:0], 32'h777);
      check("post_rst_rsv", DW'(rd_busy[1]), 32'h1);
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
